bus_fabric: RTL

- Parametrised data-bus interconnect between the core's load/store port and NUM_SLAVES memory-mapped peripherals (RAM, ROM data window, MMIO).
- Replaces the single fixed zero-wait RAM connection.
- Each slave may take a variable number of cycles; the core is stalled meanwhile.
- Unmapped accesses, malformed accesses and unresponsive slaves terminate with an error, never a hang.

---
 rtl/bus_fabric_if.sv | 19 +
 rtl/bus_fabric.sv | 130 +++++++++++++
 2 files changed

// File: rtl/bus_fabric_if.sv
// bus_fabric_if: core load/store port plus the shared and per-slave peripheral channels.
// master = core/peripheral side that drives requests and responses, slave = the fabric.
interface bus_fabric_if #(parameter int NUM_SLAVES = 4);
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic m_re, m_we, m_stall, m_err;
  logic [3:0] m_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic [3:0] s_wstrb;
  logic [NUM_SLAVES-1:0] s_re, s_we, s_ready;
  logic [NUM_SLAVES*32-1:0] s_rdata;
  modport master (
    output m_addr, m_wdata, m_re, m_we, m_wstrb, s_rdata, s_ready,
    input  m_rdata, m_stall, m_err, s_addr, s_wdata, s_wstrb, s_re, s_we
  );
  modport slave (
    input  m_addr, m_wdata, m_re, m_we, m_wstrb, s_rdata, s_ready,
    output m_rdata, m_stall, m_err, s_addr, s_wdata, s_wstrb, s_re, s_we
  );
endinterface

// File: rtl/bus_fabric.sv
// bus_fabric: stalling load/store interconnect with address decode and per-access timeout.
// Defining BUS_FABRIC_ERR_CNT_EN adds a saturating err_count, cleared by a write to 0xFFFF_FFF0.
module bus_fabric #(
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] BASE_ADDRS = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] ADDR_MASKS = {4{32'hF000_0000}},
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
`ifdef BUS_FABRIC_ERR_CNT_EN
  output logic [15:0] err_count,
`endif
  bus_fabric_if.slave bus
);
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [IW-1:0] tgt_q, tgt_d, idx;
  logic [NUM_SLAVES-1:0] re_q, re_d, we_q, we_d, sel;
  logic [7:0] cnt_q, cnt_d;
  logic err_q, err_d, hit, req, bad, clr;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((bus.m_addr & ADDR_MASKS[i*32 +: 32]) == (BASE_ADDRS[i*32 +: 32] & ADDR_MASKS[i*32 +: 32])) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
  assign sel = NUM_SLAVES'(1) << idx;
  assign req = bus.m_re | bus.m_we;
  assign bad = ~hit | (bus.m_re & bus.m_we) | clr;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    tgt_d = tgt_q;
    re_d = re_q;
    we_d = we_q;
    cnt_d = cnt_q;
    err_d = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        addr_d = bus.m_addr;
        wdata_d = bus.m_wdata;
        wstrb_d = bus.m_wstrb;
        tgt_d = idx;
        re_d = bad || !bus.m_re ? '0 : sel;
        we_d = bad || !bus.m_we ? '0 : sel;
        cnt_d = '0;
        state_d = bad ? DONE : WAIT;
        err_d = bad ? 1'b1 : err_q;
        rdata_d = bad ? '0 : rdata_q;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // a ready in the final allowed cycle still completes successfully
        if (bus.s_ready[tgt_q] || cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = DONE;
          re_d = '0;
          we_d = '0;
          cnt_d = '0;
          err_d = ~bus.s_ready[tgt_q];
          rdata_d = bus.s_ready[tgt_q] && |re_q ? bus.s_rdata[tgt_q*32 +: 32] : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      tgt_q <= '0;
      re_q <= '0;
      we_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      tgt_q <= tgt_d;
      re_q <= re_d;
      we_q <= we_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  assign bus.m_stall = state_q == WAIT || (state_q == IDLE && req);
  assign bus.m_rdata = rdata_q;
  assign bus.m_err = err_q;
  assign bus.s_addr = addr_q;
  assign bus.s_wdata = wdata_q;
  assign bus.s_wstrb = wstrb_q;
  assign bus.s_re = re_q;
  assign bus.s_we = we_q;
`ifdef BUS_FABRIC_ERR_CNT_EN
  logic [15:0] ecnt_q, ecnt_d;
  logic clr_q, clr_d;
  assign clr = bus.m_we && bus.m_addr == 32'hFFFF_FFF0;
  always_comb begin
    clr_d = state_q == IDLE && req ? clr : clr_q;
    ecnt_d = ecnt_q;
    if (state_q == DONE && err_q)
      ecnt_d = clr_q ? '0 : ecnt_q == 16'hFFFF ? ecnt_q : ecnt_q + 16'd1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      ecnt_q <= '0;
      clr_q <= 1'b0;
    end else begin
      ecnt_q <= ecnt_d;
      clr_q <= clr_d;
    end
  assign err_count = ecnt_q;
`else
  assign clr = 1'b0;
`endif
endmodule
